// File: rtl/multiport_register_file.sv
// Register file with NR combinational read ports, 2 write ports and a per-register busy scoreboard.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.

module rf_cell #(
  parameter int            DW   = 32,
  parameter int            AW   = 5,
  parameter logic [AW-1:0] ADDR = '0
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          i_we0,
  input  logic [AW-1:0] i_wa0,
  input  logic [DW-1:0] i_wd0,
  input  logic          i_we1,
  input  logic [AW-1:0] i_wa1,
  input  logic [DW-1:0] i_wd1,
  input  logic          i_rsv_en,
  input  logic [AW-1:0] i_rsv_addr,
  output logic [DW-1:0] o_q,
  output logic          o_busy
);
  logic w_h0, w_h1, w_rsv;
  logic [DW-1:0] r_q;
  logic          r_busy;

  assign w_h0  = i_we0 && (i_wa0 == ADDR);
  assign w_h1  = i_we1 && (i_wa1 == ADDR);
  assign w_rsv = i_rsv_en && (i_rsv_addr == ADDR);

  // port 1 (multi-cycle writeback) wins a same-address collision; reserve wins over clear
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_q    <= '0;
      r_busy <= 1'b0;
    end else begin
      if (w_h1)      r_q <= i_wd1;
      else if (w_h0) r_q <= i_wd0;
      if (w_rsv)             r_busy <= 1'b1;
      else if (w_h0 || w_h1) r_busy <= 1'b0;
    end
  end

  assign o_q    = r_q;
  assign o_busy = r_busy;
endmodule

module multiport_register_file #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int NR = 2
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           WE0,
  input  logic [AW-1:0]  WA0,
  input  logic [DW-1:0]  WD0,
  input  logic           WE1,
  input  logic [AW-1:0]  WA1,
  input  logic [DW-1:0]  WD1,
  input  logic [NR*AW-1:0] RA,
  output logic [NR*DW-1:0] RD,
  output logic [NR-1:0]  BUSY,
  input  logic           RSV_EN,
  input  logic [AW-1:0]  RSV_ADDR
);
  localparam int DEPTH = 1 << AW;

  logic [DEPTH-1:0][DW-1:0] w_mem;
  logic [DEPTH-1:0]         w_busy;

  // r0 is a constant, never stored
  assign w_mem[0]  = '0;
  assign w_busy[0] = 1'b0;

  for (genvar g = 1; g < DEPTH; g++) begin : g_reg
    rf_cell #(.DW(DW), .AW(AW), .ADDR(AW'(g))) u_cell (
      .CLK        (CLK),
      .RST        (RST),
      .i_we0      (WE0),
      .i_wa0      (WA0),
      .i_wd0      (WD0),
      .i_we1      (WE1),
      .i_wa1      (WA1),
      .i_wd1      (WD1),
      .i_rsv_en   (RSV_EN),
      .i_rsv_addr (RSV_ADDR),
      .o_q        (w_mem[g]),
      .o_busy     (w_busy[g])
    );
  end

  for (genvar k = 0; k < NR; k++) begin : g_rd
    logic [AW-1:0] w_ra;
    logic [DW-1:0] w_rd;
    logic          w_bsy;

    assign w_ra = RA[k*AW +: AW];

    always_comb begin
      w_rd  = '0;
      w_bsy = 1'b0;
      if (!RST && (w_ra != '0)) begin
        w_rd  = w_mem[w_ra];
        w_bsy = w_busy[w_ra];
`ifdef REGFILE_BYPASS_EN
        // forwarded data means the result has arrived; only a same-cycle reserve keeps it busy
        if (WE1 && (WA1 == w_ra)) begin
          w_rd  = WD1;
          w_bsy = RSV_EN && (RSV_ADDR == w_ra);
        end else if (WE0 && (WA0 == w_ra)) begin
          w_rd  = WD0;
          w_bsy = RSV_EN && (RSV_ADDR == w_ra);
        end
`endif
      end
    end

    assign RD[k*DW +: DW] = w_rd;
    assign BUSY[k]        = w_bsy;
  end
endmodule

// File: tb/tb_multiport_register_file.sv
// Directed bench: stimulus pushes expected read-port values, a monitor pops and compares them.
module tb_multiport_register_file;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  // instance A: default 32b x 32, 2 ports
  logic        a_WE0, a_WE1, a_RSV_EN;
  logic [4:0]  a_WA0, a_WA1, a_RSV_ADDR;
  logic [31:0] a_WD0, a_WD1;
  logic [9:0]  a_RA;
  logic [63:0] a_RD;
  logic [1:0]  a_BUSY;

  // instance B: 16b x 16, 4 ports
  logic        b_WE0, b_WE1, b_RSV_EN;
  logic [3:0]  b_WA0, b_WA1, b_RSV_ADDR;
  logic [15:0] b_WD0, b_WD1;
  logic [15:0] b_RA;
  logic [63:0] b_RD;
  logic [3:0]  b_BUSY;

  multiport_register_file #(.DW(32), .AW(5), .NR(2)) u_a (
    .CLK(CLK), .RST(RST),
    .WE0(a_WE0), .WA0(a_WA0), .WD0(a_WD0),
    .WE1(a_WE1), .WA1(a_WA1), .WD1(a_WD1),
    .RA(a_RA), .RD(a_RD), .BUSY(a_BUSY),
    .RSV_EN(a_RSV_EN), .RSV_ADDR(a_RSV_ADDR)
  );

  multiport_register_file #(.DW(16), .AW(4), .NR(4)) u_b (
    .CLK(CLK), .RST(RST),
    .WE0(b_WE0), .WA0(b_WA0), .WD0(b_WD0),
    .WE1(b_WE1), .WA1(b_WA1), .WD1(b_WD1),
    .RA(b_RA), .RD(b_RD), .BUSY(b_BUSY),
    .RSV_EN(b_RSV_EN), .RSV_ADDR(b_RSV_ADDR)
  );

  typedef struct {
    int          inst;
    int          port;
    logic [31:0] rd;
    logic        bsy;
    bit          cb;
    string       nm;
  } exp_t;

  exp_t q[$];
  event ev_chk;
  int   n_chk = 0;
  int   n_err = 0;

  always begin
    @(ev_chk);
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] ard;
      logic        abs;
      e = q.pop_front();
      if (e.inst == 0) begin
        ard = a_RD[e.port*32 +: 32];
        abs = a_BUSY[e.port];
      end else begin
        ard = {16'h0, b_RD[e.port*16 +: 16]};
        abs = b_BUSY[e.port];
      end
      n_chk++;
      if (ard !== e.rd || (e.cb && abs !== e.bsy)) begin
        n_err++;
        $display("FAIL %s: rd=%h busy=%b, required rd=%h busy=%b", e.nm, ard, abs, e.rd, e.bsy);
      end
    end
  end

  task automatic chk(input int inst, input int port, input logic [31:0] rd,
                     input logic bsy, input bit cb, input string nm);
    exp_t e;
    #1;
    e.inst = inst; e.port = port; e.rd = rd; e.bsy = bsy; e.cb = cb; e.nm = nm;
    q.push_back(e);
    -> ev_chk;
    #1;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic a_idle();
    a_WE0 = 0; a_WE1 = 0; a_RSV_EN = 0;
    a_WA0 = 0; a_WA1 = 0; a_RSV_ADDR = 0;
    a_WD0 = 0; a_WD1 = 0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, required finish before 20000");
    $fatal(1);
  end

  initial begin
    a_idle(); a_RA = '0;
    b_WE0 = 0; b_WE1 = 0; b_RSV_EN = 0; b_WA0 = 0; b_WA1 = 0; b_RSV_ADDR = 0;
    b_WD0 = 0; b_WD1 = 0; b_RA = '0;
    a_RA[4:0] = 5'd5; a_RA[9:5] = 5'd9;
    chk(0, 0, 32'h0, 1'b0, 1, "reset_a_p0");
    chk(0, 1, 32'h0, 1'b0, 1, "reset_a_p1");
    chk(1, 0, 32'h0, 1'b0, 1, "reset_b_p0");
    tick(); RST = 1'b0; tick();

    // reserve + write r5, then async reset mid-cycle
    a_WE0 = 1; a_WA0 = 5; a_WD0 = 32'h1234; a_RSV_EN = 1; a_RSV_ADDR = 5;
    tick(); a_idle();
    chk(0, 0, 32'h1234, 1'b1, 1, "r5_written");
    RST = 1'b1;
    chk(0, 0, 32'h0, 1'b0, 1, "r5_async_rst");
    RST = 1'b0;
    tick();
    chk(0, 0, 32'h0, 1'b0, 1, "r5_after_rst");

    // write to r0 is ignored
    a_RA[4:0] = 5'd0;
    a_WE0 = 1; a_WA0 = 0; a_WD0 = 32'hFFFF_FFFF;
    chk(0, 0, 32'h0, 1'b0, 1, "r0_wr_same_cycle");
    tick(); a_idle();
    chk(0, 0, 32'h0, 1'b0, 1, "r0_wr_next");
    a_RSV_EN = 1; a_RSV_ADDR = 0;
    tick(); a_idle();
    chk(0, 0, 32'h0, 1'b0, 1, "r0_rsv_ignored");

    // dual write collision on r7
    a_RA[9:5] = 5'd7;
    a_WE0 = 1; a_WA0 = 7; a_WD0 = 32'hAAAA;
    a_WE1 = 1; a_WA1 = 7; a_WD1 = 32'h5555;
    chk(0, 1, BYP ? 32'h5555 : 32'h0, 1'b0, 1, "r7_collide_pre");
    tick(); a_idle();
    chk(0, 1, 32'h5555, 1'b0, 1, "r7_collide");

    // scoreboard on r9
    a_RA[4:0] = 5'd9;
    a_RSV_EN = 1; a_RSV_ADDR = 9;
    tick(); a_idle();
    chk(0, 0, 32'h0, 1'b1, 1, "r9_reserved");
    a_WE1 = 1; a_WA1 = 9; a_WD1 = 32'h77;
    chk(0, 0, BYP ? 32'h77 : 32'h0, BYP ? 1'b0 : 1'b1, 1, "r9_wb_pre");
    tick(); a_idle();
    chk(0, 0, 32'h77, 1'b0, 1, "r9_wb");
    a_RSV_EN = 1; a_RSV_ADDR = 9; a_WE1 = 1; a_WA1 = 9; a_WD1 = 32'h88;
    chk(0, 0, BYP ? 32'h88 : 32'h77, 1'b0, 0, "r9_rsv_wr_pre");
    tick(); a_idle();
    chk(0, 0, 32'h88, 1'b1, 1, "r9_rsv_wr");
    a_WE0 = 1; a_WA0 = 9; a_WD0 = 32'h99;
    tick(); a_idle();
    chk(0, 0, 32'h99, 1'b0, 1, "r9_wb_port0");
    a_RSV_EN = 1; a_RSV_ADDR = 9;
    tick();
    tick(); a_idle();
    chk(0, 0, 32'h99, 1'b1, 1, "r9_double_rsv");

    // write-to-read visibility on r3
    a_RA[4:0] = 5'd3;
    a_WE0 = 1; a_WA0 = 3; a_WD0 = 32'h1111;
    tick(); a_idle();
    a_WE0 = 1; a_WA0 = 3; a_WD0 = 32'hBEEF;
    chk(0, 0, BYP ? 32'hBEEF : 32'h1111, 1'b0, 1, "r3_same_cycle");
    tick(); a_idle();
    chk(0, 0, 32'hBEEF, 1'b0, 1, "r3_next");

    // 4-port instance: r1..r4
    b_WE0 = 1; b_WA0 = 1; b_WD0 = 16'h0101; b_WE1 = 1; b_WA1 = 2; b_WD1 = 16'h0202;
    tick();
    b_WE0 = 1; b_WA0 = 3; b_WD0 = 16'h0303; b_WE1 = 1; b_WA1 = 4; b_WD1 = 16'h0404;
    tick();
    b_WE0 = 0; b_WE1 = 0;
    b_RA = {4'd4, 4'd3, 4'd2, 4'd1};
    chk(1, 0, 32'h0101, 1'b0, 1, "b_p0_r1");
    chk(1, 1, 32'h0202, 1'b0, 1, "b_p1_r2");
    chk(1, 2, 32'h0303, 1'b0, 1, "b_p2_r3");
    chk(1, 3, 32'h0404, 1'b0, 1, "b_p3_r4");
    b_RA = {4'd1, 4'd2, 4'd3, 4'd4};
    chk(1, 0, 32'h0404, 1'b0, 1, "b_p0_r4");
    chk(1, 3, 32'h0101, 1'b0, 1, "b_p3_r1");

    #5;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain: pending=%0d, required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
